// File: rtl/pac_mover_if.sv
// Wall-map read port and tile-map write port between pac_mover and the maze/tile memories.
interface pac_mover_if #(
    parameter int unsigned ADDR_W = 11
);
    logic [ADDR_W-1:0] wall_addr;
    logic [1:0]        wall_data;
    logic              tile_we;
    logic [ADDR_W-1:0] tile_waddr;
    logic [2:0]        tile_wdata;

    modport master (
        output wall_addr,
        input  wall_data,
        output tile_we,
        output tile_waddr,
        output tile_wdata
    );

    modport slave (
        input  wall_addr,
        output wall_data,
        input  tile_we,
        input  tile_waddr,
        input  tile_wdata
    );
endinterface

// File: rtl/pac_mover.sv
// Moves Pac-Man one tile per game tick on the maze grid and updates the renderer tile map.
// Optional pellet scoring is enabled by defining PAC_PELLET_EN.
module pac_mover #(
    parameter int unsigned COLS    = 40,
    parameter int unsigned ROWS    = 30,
    parameter int unsigned START_X = 20,
    parameter int unsigned START_Y = 15,
    parameter int unsigned ADDR_W  = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        dir_valid,
    input  logic [1:0]  dir_req,
    pac_mover_if.master bus,
    output logic [5:0]  pac_x,
    output logic [4:0]  pac_y,
    output logic        busy,
    output logic        moved,
    output logic [9:0]  score
);
    localparam logic [1:0] DirRight = 2'd0;
    localparam logic [1:0] DirLeft  = 2'd1;
    localparam logic [1:0] DirUp    = 2'd2;

    typedef enum logic [3:0] {
        StInit, StIdle, StRdReq, StChkReq, StRdCur, StChkCur, StErase, StDraw, StDone
    } state_t;

    typedef struct packed {
        logic       oob;
        logic [4:0] y;
        logic [5:0] x;
    } tgt_t;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [5:0] x, input logic [4:0] y);
        return ADDR_W'(32'(y) * COLS + 32'(x));
    endfunction

    // x wraps around the tunnel; y leaving the grid counts as a wall
    function automatic tgt_t target(input logic [1:0] dir, input logic [5:0] x,
                                    input logic [4:0] y);
        tgt_t t;
        t.x   = x;
        t.y   = y;
        t.oob = 1'b0;
        case (dir)
            DirRight: t.x = (x == 6'(COLS - 1)) ? 6'd0 : x + 6'd1;
            DirLeft:  t.x = (x == 6'd0) ? 6'(COLS - 1) : x - 6'd1;
            DirUp:    if (y == 5'd0) t.oob = 1'b1; else t.y = y - 5'd1;
            default:  if (y == 5'(ROWS - 1)) t.oob = 1'b1; else t.y = y + 5'd1;
        endcase
        return t;
    endfunction

    localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_Y * COLS + START_X);

    state_t            state_q;
    logic [1:0]        cur_dir_q, pend_dir_q;
    logic              pend_valid_q;
    logic [5:0]        pac_x_q, tgt_x_q;
    logic [4:0]        pac_y_q, tgt_y_q;
    logic              tgt_oob_q;
    logic [ADDR_W-1:0] wall_addr_q;
    logic              moved_q;
    tgt_t              tgt_pend, tgt_cur;
    logic              free;

    always_comb begin
        tgt_pend = target(pend_dir_q, pac_x_q, pac_y_q);
        tgt_cur  = target(cur_dir_q, pac_x_q, pac_y_q);
        free     = !tgt_oob_q && !bus.wall_data[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StInit;
            cur_dir_q    <= DirLeft;
            pend_dir_q   <= DirRight;
            pend_valid_q <= 1'b0;
            pac_x_q      <= 6'(START_X);
            pac_y_q      <= 5'(START_Y);
            tgt_x_q      <= 6'(START_X);
            tgt_y_q      <= 5'(START_Y);
            tgt_oob_q    <= 1'b0;
            wall_addr_q  <= '0;
            moved_q      <= 1'b0;
        end else begin
            moved_q <= 1'b0;
            case (state_q)
                StInit: state_q <= StIdle;
                StIdle: begin
                    if (tick) begin
                        if (pend_valid_q && pend_dir_q != cur_dir_q) begin
                            {tgt_oob_q, tgt_y_q, tgt_x_q} <= tgt_pend;
                            wall_addr_q <= addr_of(tgt_pend.x, tgt_pend.y);
                            state_q     <= StRdReq;
                        end else begin
                            {tgt_oob_q, tgt_y_q, tgt_x_q} <= tgt_cur;
                            wall_addr_q <= addr_of(tgt_cur.x, tgt_cur.y);
                            state_q     <= StRdCur;
                        end
                    end
                end
                StRdReq: state_q <= StChkReq;
                StChkReq: begin
                    if (free) begin
                        cur_dir_q    <= pend_dir_q;
                        pend_valid_q <= 1'b0;
                        state_q      <= StErase;
                    end else begin
                        // blocked turn stays pending and is retried on later ticks
                        {tgt_oob_q, tgt_y_q, tgt_x_q} <= tgt_cur;
                        wall_addr_q <= addr_of(tgt_cur.x, tgt_cur.y);
                        state_q     <= StRdCur;
                    end
                end
                StRdCur:  state_q <= StChkCur;
                StChkCur: state_q <= free ? StErase : StDone;
                StErase:  state_q <= StDraw;
                StDraw: begin
                    pac_x_q <= tgt_x_q;
                    pac_y_q <= tgt_y_q;
                    moved_q <= 1'b1;
                    state_q <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StInit;
            endcase
            // a new request overrides a same-cycle clear
            if (dir_valid) begin
                pend_dir_q   <= dir_req;
                pend_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.tile_we    = 1'b0;
        bus.tile_waddr = '0;
        bus.tile_wdata = 3'd0;
        case (state_q)
            StInit: begin
                bus.tile_we    = !reset;
                bus.tile_waddr = StartAddr;
                bus.tile_wdata = 3'd1;
            end
            StErase: begin
                bus.tile_we    = 1'b1;
                bus.tile_waddr = addr_of(pac_x_q, pac_y_q);
            end
            StDraw: begin
                bus.tile_we    = 1'b1;
                bus.tile_waddr = addr_of(tgt_x_q, tgt_y_q);
                bus.tile_wdata = 3'd1;
            end
            default: ;
        endcase
    end

`ifdef PAC_PELLET_EN
    logic [9:0] score_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
        end else if ((state_q == StChkReq || state_q == StChkCur) && free &&
                     bus.wall_data[1] && score_q != 10'd1023) begin
            score_q <= score_q + 10'd1;
        end
    end

    assign score = score_q;
`else
    logic unused_pellet;
    assign unused_pellet = bus.wall_data[1];
    assign score         = '0;
`endif

    assign bus.wall_addr = wall_addr_q;
    assign pac_x         = pac_x_q;
    assign pac_y         = pac_y_q;
    assign busy          = (state_q != StIdle);
    assign moved         = moved_q;
endmodule

// File: tb/tb_pac_mover.sv
// Directed vector bench for pac_mover: moves, turns, wrap, blocking, tick drop, reset abort.
module tb_pac_mover;
    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       dir_valid;
    logic [1:0] dir_req;
    logic [5:0] pac_x;
    logic [4:0] pac_y;
    logic       busy;
    logic       moved;
    logic [9:0] score;

    logic [1:0] wall_map [0:1199];
    int n_vec = 0;
    int n_err = 0;

`ifdef PAC_PELLET_EN
    localparam int ExpScore = 1;
`else
    localparam int ExpScore = 0;
`endif

    pac_mover_if #(.ADDR_W(11)) bus ();

    pac_mover dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .dir_valid(dir_valid),
        .dir_req  (dir_req),
        .bus      (bus),
        .pac_x    (pac_x),
        .pac_y    (pac_y),
        .busy     (busy),
        .moved    (moved),
        .score    (score)
    );

    always #5 clk = ~clk;

    // wall ROM model: one cycle read latency
    always @(posedge clk) bus.wall_data <= wall_map[bus.wall_addr];

    typedef struct {
        bit         req_v;
        logic [1:0] req;
        int         wall_set;
        int         wall_clr;
        bit         dbl;
        int         n_wr;
        int         er_off;
        int         old_a;
        int         new_a;
        int         mv_off;
        int         x;
        int         y;
    } vec_t;

    function automatic vec_t mk(bit rv, logic [1:0] rq, int ws, int wc, bit db, int nw, int er,
                                int oa, int na, int mv, int x, int y);
        vec_t v;
        v.req_v = rv; v.req = rq; v.wall_set = ws; v.wall_clr = wc; v.dbl = db;
        v.n_wr = nw; v.er_off = er; v.old_a = oa; v.new_a = na; v.mv_off = mv;
        v.x = x; v.y = y;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    int  tr_addr [1:12];
    int  tr_data [1:12];
    bit  tr_we   [1:12];
    bit  tr_mv   [1:12];
    bit  tr_busy [1:12];

    task automatic apply(input vec_t v, input string tag);
        int nw;
        int nm;
        if (v.wall_set >= 0) wall_map[v.wall_set][0] = 1'b1;
        if (v.wall_clr >= 0) wall_map[v.wall_clr][0] = 1'b0;
        if (v.req_v) begin
            dir_valid = 1'b1;
            dir_req   = v.req;
            @(negedge clk);
            dir_valid = 1'b0;
        end
        tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tick       = (k == 1) && v.dbl;
            tr_we[k]   = bus.tile_we;
            tr_addr[k] = int'(bus.tile_waddr);
            tr_data[k] = int'(bus.tile_wdata);
            tr_mv[k]   = moved;
            tr_busy[k] = busy;
        end
        nw = 0;
        nm = 0;
        for (int k = 1; k <= 12; k++) begin
            nw += int'(tr_we[k]);
            nm += int'(tr_mv[k]);
        end
        chk({tag, " write count"}, nw, v.n_wr);
        if (v.n_wr == 2) begin
            chk({tag, " erase we"}, int'(tr_we[v.er_off]), 1);
            chk({tag, " erase addr"}, tr_addr[v.er_off], v.old_a);
            chk({tag, " erase data"}, tr_data[v.er_off], 0);
            chk({tag, " draw addr"}, tr_addr[v.er_off + 1], v.new_a);
            chk({tag, " draw data"}, tr_data[v.er_off + 1], 1);
        end
        chk({tag, " moved count"}, nm, (v.mv_off > 0) ? 1 : 0);
        if (v.mv_off > 0) chk({tag, " moved timing"}, int'(tr_mv[v.mv_off]), 1);
        chk({tag, " idle after"}, int'(tr_busy[12]), 0);
        chk({tag, " pac_x"}, int'(pac_x), v.x);
        chk({tag, " pac_y"}, int'(pac_y), v.y);
    endtask

    // called with reset just released, sampled inside the INIT cycle
    task automatic check_init(input string tag);
        #1;
        chk({tag, " init we"}, int'(bus.tile_we), 1);
        chk({tag, " init addr"}, int'(bus.tile_waddr), 620);
        chk({tag, " init data"}, int'(bus.tile_wdata), 1);
        chk({tag, " pac_x"}, int'(pac_x), 20);
        chk({tag, " pac_y"}, int'(pac_y), 15);
        chk({tag, " score"}, int'(score), 0);
        @(negedge clk);
        chk({tag, " busy low"}, int'(busy), 0);
        chk({tag, " we low"}, int'(bus.tile_we), 0);
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = mk(1, 2'd0, -1, -1, 0, 2, 3, 620, 621, 5, 21, 15);   // turn RIGHT accepted
        tbl[1] = mk(0, 2'd0, -1, -1, 0, 2, 3, 621, 622, 5, 22, 15);   // keep going
        tbl[2] = mk(1, 2'd3, 662, -1, 0, 2, 5, 622, 623, 7, 23, 15);  // DOWN walled, buffered
        tbl[3] = mk(0, 2'd0, -1, 662, 0, 2, 3, 623, 663, 5, 23, 16);  // buffered DOWN taken
        tbl[4] = mk(1, 2'd2, -1, -1, 0, 2, 3, 663, 623, 5, 23, 15);   // UP
        tbl[5] = mk(1, 2'd1, -1, -1, 1, 2, 3, 623, 622, 5, 22, 15);   // double tick dropped

        for (int i = 0; i < 1200; i++) wall_map[i] = 2'b00;
        tick      = 1'b0;
        dir_valid = 1'b0;
        dir_req   = 2'd0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset moved", int'(moved), 0);
        chk("reset tile_we", int'(bus.tile_we), 0);
        reset = 1'b0;
        check_init("t1");

        for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("v%0d", i));

        // walk left to column 0, then wrap through the tunnel
        for (int i = 0; i < 22; i++)
            apply(mk(0, 2'd0, -1, -1, 0, 2, 3, 622 - i, 621 - i, 5, 21 - i, 15),
                  $sformatf("left%0d", i));
        apply(mk(0, 2'd0, -1, -1, 0, 2, 3, 600, 639, 5, 39, 15), "wrap");

        // climb to the top row
        for (int j = 0; j < 15; j++)
            apply(mk(j == 0, 2'd2, -1, -1, 0, 2, 3, (15 - j) * 40 + 39, (14 - j) * 40 + 39, 5,
                     39, 14 - j), $sformatf("up%0d", j));
        apply(mk(1, 2'd1, -1, -1, 0, 2, 3, 39, 38, 5, 38, 0), "turn left top");

        // UP off-grid and wall ahead: nothing moves, UP stays pending
        apply(mk(1, 2'd2, 37, -1, 0, 0, 0, 0, 0, 0, 38, 0), "t4 blocked");
        apply(mk(0, 2'd0, -1, 37, 0, 2, 5, 38, 37, 7, 37, 0), "t4 pend kept");

        // reset during ERASE aborts the move
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort erase we", int'(bus.tile_we), 1);
        chk("abort erase addr", int'(bus.tile_waddr), 37);
        reset = 1'b1;
        #1;
        chk("abort we in reset", int'(bus.tile_we), 0);
        chk("abort pac_x", int'(pac_x), 20);
        chk("abort pac_y", int'(pac_y), 15);
        chk("abort busy", int'(busy), 1);
        @(negedge clk);
        reset = 1'b0;
        check_init("abort");

        // pellet on the RIGHT neighbour
        wall_map[621] = 2'b10;
        apply(mk(1, 2'd0, -1, -1, 0, 2, 3, 620, 621, 5, 21, 15), "pellet");
        chk("pellet score", int'(score), ExpScore);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6 erase we", int'(bus.tile_we), 1);
        chk("t6 erase addr", int'(bus.tile_waddr), 621);
        reset = 1'b1;
        #1;
        chk("t6 score reset", int'(score), 0);
        @(negedge clk);
        reset = 1'b0;
        check_init("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
